ascii_rx_sched: RTL and testbench

//  Schedules the single 8-bit CPU serial-RX register port between two character sources:
//  - live UART RX bytes;
//  - playback of a downloaded text buffer.

---
 rtl/ascii_rx_sched_pkg.sv | 17 +
 rtl/ascii_rx_sched_gap_timer.sv | 31 +++
 rtl/ascii_rx_sched.sv | 149 ++++++++++++++
 tb/tb_ascii_rx_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_rx_sched_pkg.sv
// Shared types and constants for the serial-RX scheduler: FSM states, ASCII codes,
// status bit positions and the playback LF->CR mapping.
package ascii_rx_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, HOLD, GAP} state_e;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   localparam int STAT_RDY = 7;
   localparam int STAT_OVR = 6;

   function automatic logic [7:0] xlate_lf(input logic [7:0] c, input logic en);
      return (en && (c == ASCII_LF)) ? ASCII_CR : c;
   endfunction

endpackage

// File: rtl/ascii_rx_sched_gap_timer.sv
// Loadable down-counter pacing playback; holds at zero until reloaded.
module gap_timer #(
   parameter int W = 17
) (
   input  logic         clock_in,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = value;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clock_in or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ascii_rx_sched.sv
// Arbitrates the CPU serial-RX register between live UART bytes and paced text-buffer playback.
//  state | meaning
//  IDLE  | no playback
//  FETCH | buffer read strobe at ptr
//  WAIT  | buffer data returns, captured into pend
//  LOAD  | pend waits for an empty holding register
//  HOLD  | playback char waits for the CPU data read
//  GAP   | post-read pacing delay
module ascii_rx_sched
   import ascii_rx_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int CHAR_GAP     = 4000,
   parameter int LINE_GAP     = 100000,
   parameter bit TRANSLATE_LF = 1'b1
) (
   input  logic              clock_in,
   input  logic              rst,
   input  logic              uart_valid,
   input  logic [7:0]        uart_data,
   input  logic              play_start,
   input  logic [ADDR_W-1:0] play_last,
   input  logic              play_abort,
   output logic              buf_rd,
   output logic [ADDR_W-1:0] buf_addr,
   input  logic [7:0]        buf_data,
   input  logic              cs,
   input  logic              address,
   output logic [7:0]        dout,
   output logic              play_busy,
   output logic              overrun
);

   localparam int GAP_MAX = (CHAR_GAP > LINE_GAP) ? CHAR_GAP : LINE_GAP;
   localparam int TW      = $clog2(GAP_MAX + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, last_q, last_d;
   logic [7:0]        pend_q, pend_d, hold_q, hold_d, dout_q, dout_d;
   logic              rdy_q, rdy_d, overrun_q, overrun_d;
   logic              rd_data, free, pb_load, tmr_load, tmr_zero;
   logic [TW-1:0]     tmr_value;
   logic [7:0]        status;

   assign rd_data   = cs && !address;
   // A data read in the same cycle frees the register for a simultaneous live byte.
   assign free      = !rdy_q || rd_data;
   assign pb_load   = (state_q == LOAD) && !rdy_q && !uart_valid && !play_abort;
   assign tmr_value = (pend_q == ASCII_CR) ? TW'(LINE_GAP) : TW'(CHAR_GAP);

   gap_timer #(.W(TW)) u_gap_timer (
      .clock_in (clock_in),
      .rst      (rst),
      .load     (tmr_load),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   always_comb begin
      hold_d    = hold_q;
      rdy_d     = rdy_q;
      overrun_d = overrun_q && !rd_data;
      dout_d    = dout_q;
      status    = 8'h00;
      status[STAT_RDY] = rdy_q;
      status[STAT_OVR] = overrun_q;
      if (cs)
         dout_d = address ? status : hold_q;
      if (uart_valid) begin
         if (free) begin
            hold_d = uart_data;
            rdy_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (pb_load) begin
         hold_d = pend_q;
         rdy_d  = 1'b1;
      end else if (rd_data) begin
         rdy_d = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      last_d   = last_q;
      pend_d   = pend_q;
      tmr_load = 1'b0;
      case (state_q)
         IDLE: if (play_start && !play_abort) begin
            ptr_d   = '0;
            last_d  = play_last;
            state_d = FETCH;
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            pend_d  = xlate_lf(buf_data, TRANSLATE_LF);
            state_d = LOAD;
         end
         LOAD: if (pb_load) state_d = HOLD;
         HOLD: if (rd_data) begin
            tmr_load = 1'b1;
            state_d  = GAP;
         end
         GAP: if (tmr_zero) begin
            // Equality stop, so play_last at the top of the address space never wraps.
            if (ptr_q == last_q) begin
               state_d = IDLE;
            end else begin
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
      if (play_abort)
         state_d = IDLE;
   end

   always_ff @(posedge clock_in or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         last_q    <= '0;
         pend_q    <= 8'h00;
         hold_q    <= 8'h00;
         dout_q    <= 8'h00;
         rdy_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         last_q    <= last_d;
         pend_q    <= pend_d;
         hold_q    <= hold_d;
         dout_q    <= dout_d;
         rdy_q     <= rdy_d;
         overrun_q <= overrun_d;
      end
   end

   assign buf_rd    = (state_q == FETCH);
   assign buf_addr  = ptr_q;
   assign play_busy = (state_q != IDLE);
   assign dout      = dout_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ascii_rx_sched.sv
// Directed bench for ascii_rx_sched: a timeline model of register and playback behaviour
// checked every cycle, plus literal expectations for the key read values.
module tb_ascii_rx_sched;

   localparam int AW = 4;
   localparam int CG = 4;
   localparam int LG = 10;

   logic          clock_in = 1'b0;
   logic          rst;
   logic          uart_valid = 1'b0;
   logic [7:0]    uart_data = 8'h00;
   logic          play_start = 1'b0;
   logic [AW-1:0] play_last = '0;
   logic          play_abort = 1'b0;
   logic          buf_rd;
   logic [AW-1:0] buf_addr;
   logic [7:0]    buf_data = 8'h00;
   logic          cs = 1'b0;
   logic          address = 1'b0;
   logic [7:0]    dout;
   logic          play_busy;
   logic          overrun;

   logic [7:0]    mem [16];
   int            errors = 0;
   int            checks = 0;

   always #5 clock_in = ~clock_in;

   ascii_rx_sched #(
      .ADDR_W(AW), .CHAR_GAP(CG), .LINE_GAP(LG), .TRANSLATE_LF(1'b1)
   ) dut (
      .clock_in(clock_in), .rst(rst),
      .uart_valid(uart_valid), .uart_data(uart_data),
      .play_start(play_start), .play_last(play_last), .play_abort(play_abort),
      .buf_rd(buf_rd), .buf_addr(buf_addr), .buf_data(buf_data),
      .cs(cs), .address(address), .dout(dout),
      .play_busy(play_busy), .overrun(overrun)
   );

   // Text RAM: data appears the cycle after the read strobe.
   always @(posedge clock_in) if (buf_rd) buf_data <= mem[buf_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: register contents plus a timeline of playback events in edge numbers.
   int         ecnt = 0;
   bit         m_busy = 0, m_pend = 0, m_pbhold = 0, m_gap = 0, m_bufrd = 0;
   bit         m_rdy = 0, m_ovr = 0;
   int         m_idx = 0, m_last = 0, m_load_ok = 0, m_gap_exit = 0;
   logic [7:0] m_data = 8'h00, m_dout = 8'h00, m_pchar = 8'h00;

   function automatic logic [7:0] xl(input logic [7:0] c);
      return (c == 8'h0A) ? 8'h0D : c;
   endfunction

   task automatic m_fetch();
      m_bufrd   = 1;
      m_pend    = 1;
      m_load_ok = ecnt + 3;
      m_pchar   = xl(mem[m_idx]);
   endtask

   always @(posedge clock_in or posedge rst) begin : model
      bit rdx, pbload, b0, r0;
      if (rst) begin
         ecnt = 0; m_busy = 0; m_pend = 0; m_pbhold = 0; m_gap = 0; m_bufrd = 0;
         m_rdy = 0; m_ovr = 0; m_idx = 0; m_data = 8'h00; m_dout = 8'h00;
      end else begin
         ecnt++;
         m_bufrd = 0;
         b0  = m_busy;
         r0  = m_rdy;
         rdx = cs && !address;
         pbload = m_pend && (ecnt >= m_load_ok) && !r0 && !uart_valid && !play_abort;
         if (cs) m_dout = address ? {r0, m_ovr, 6'b0} : m_data;
         if (rdx) m_ovr = 0;
         if (uart_valid && r0 && !rdx) m_ovr = 1;
         if (uart_valid) begin
            if (!r0 || rdx) begin m_data = uart_data; m_rdy = 1; end
         end else if (pbload) begin
            m_data = m_pchar; m_rdy = 1;
         end else if (rdx) begin
            m_rdy = 0;
         end
         if (play_abort) begin
            m_busy = 0; m_pend = 0; m_pbhold = 0; m_gap = 0;
         end else begin
            if (rdx && m_pbhold) begin
               m_pbhold   = 0;
               m_gap      = 1;
               m_gap_exit = ecnt + ((m_pchar == 8'h0D) ? LG : CG) + 1;
            end
            if (pbload) begin m_pend = 0; m_pbhold = 1; end
            if (m_gap && ecnt == m_gap_exit) begin
               m_gap = 0;
               if (m_idx == m_last) m_busy = 0;
               else begin m_idx++; m_fetch(); end
            end
            if (play_start && !b0) begin
               m_busy = 1; m_idx = 0; m_last = int'(play_last); m_fetch();
            end
         end
      end
   end

   always @(negedge clock_in) begin
      if (!rst) begin
         chk("dout", dout, m_dout);
         chk("overrun", overrun, m_ovr);
         chk("play_busy", play_busy, m_busy);
         chk("buf_rd", buf_rd, m_bufrd);
         if (m_bufrd) chk("buf_addr", buf_addr, m_idx);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic cpu_rd(input logic a, output logic [7:0] v);
      cs = 1'b1; address = a;
      @(negedge clock_in);
      cs = 1'b0; address = 1'b0;
      v = dout;
   endtask

   task automatic send(input logic [7:0] b);
      uart_valid = 1'b1; uart_data = b;
      @(negedge clock_in);
      uart_valid = 1'b0;
   endtask

   task automatic play(input logic [AW-1:0] last);
      play_last = last; play_start = 1'b1;
      @(negedge clock_in);
      play_start = 1'b0;
   endtask

   task automatic abort_pulse();
      play_abort = 1'b1;
      @(negedge clock_in);
      play_abort = 1'b0;
   endtask

   // Poll status until rdy, then read data; n returns the number of polls.
   task automatic poll_rd(input string nm, output logic [7:0] v, output int n);
      logic [7:0] s;
      s = 8'h00; n = 0; v = 8'h00;
      while (!s[7] && n < 300) begin
         cpu_rd(1'b1, s);
         n++;
      end
      chk(nm, s[7], 1'b1);
      if (s[7]) cpu_rd(1'b0, v);
   endtask

   task automatic wait_idle(input string nm, output int k);
      k = 0;
      while (play_busy && k < 300) begin step(); k++; end
      chk(nm, play_busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      int n, k;
      rst = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      step(2);
      chk("rst dout", dout, 8'h00);
      chk("rst buf_rd", buf_rd, 1'b0);
      chk("rst buf_addr", buf_addr, 0);
      chk("rst busy", play_busy, 1'b0);
      chk("rst overrun", overrun, 1'b0);
      rst = 1'b0;
      step();
      cpu_rd(1'b1, v); chk("rst status", v, 8'h00);

      // overrun
      send(8'h31); send(8'h32);
      cpu_rd(1'b1, v); chk("ovr status", v, 8'hC0);
      cpu_rd(1'b0, v); chk("ovr data", v, 8'h31);
      cpu_rd(1'b1, v); chk("ovr status after", v, 8'h00);

      // live byte in the same cycle as a data read
      send(8'h31);
      cs = 1'b1; address = 1'b0; uart_valid = 1'b1; uart_data = 8'h33;
      step();
      cs = 1'b0; uart_valid = 1'b0;
      chk("simul dout", dout, 8'h31);
      cpu_rd(1'b1, v); chk("simul status", v, 8'h80);
      cpu_rd(1'b0, v); chk("simul data", v, 8'h33);
      chk("simul overrun", overrun, 1'b0);

      // playback "A\nB"
      mem[0] = 8'h41; mem[1] = 8'h0A; mem[2] = 8'h42;
      play(2);
      poll_rd("pb rdy0", v, n); chk("pb char0", v, 8'h41);
      poll_rd("pb rdy1", v, n); chk("pb char1", v, 8'h0D); chk("pb gap0", n >= CG, 1'b1);
      poll_rd("pb rdy2", v, n); chk("pb char2", v, 8'h42); chk("pb gap1", n >= LG, 1'b1);
      wait_idle("pb idle", k); chk("pb gap2", k >= CG, 1'b1);

      // live byte beats a pending playback char
      mem[0] = 8'h48;
      send(8'h77);
      play(0);
      step(6);
      chk("live busy", play_busy, 1'b1);
      cpu_rd(1'b0, v); chk("live first", v, 8'h77);
      send(8'h55);
      poll_rd("live rdy", v, n); chk("live 55", v, 8'h55);
      poll_rd("live pb rdy", v, n); chk("live pb", v, 8'h48);
      chk("live overrun", overrun, 1'b0);
      wait_idle("live idle", k);

      // full address range ends on equality, not wrap
      for (int i = 0; i < 16; i++) mem[i] = 8'h61 + 8'(i);
      mem[5] = 8'h0A;
      play(4'hF);
      for (int i = 0; i < 16; i++) begin
         poll_rd("full rdy", v, n);
         chk("full char", v, (i == 5) ? 8'h0D : 8'h61 + 8'(i));
      end
      wait_idle("full idle", k);
      mem[5] = 8'h66;

      // abort in GAP after the second char
      play(4'd9);
      poll_rd("abort rdy0", v, n); chk("abort c0", v, 8'h61);
      poll_rd("abort rdy1", v, n); chk("abort c1", v, 8'h62);
      step(2);
      abort_pulse();
      chk("abort busy", play_busy, 1'b0);
      k = 0;
      for (int i = 0; i < 30; i++) begin step(); if (buf_rd) k++; end
      chk("abort no buf_rd", k, 0);
      play(4'd9);
      k = 0;
      while (!buf_rd && k < 10) begin step(); k++; end
      chk("restart buf_rd", buf_rd, 1'b1);
      chk("restart addr", buf_addr, 0);
      poll_rd("restart rdy", v, n); chk("restart c0", v, 8'h61);
      abort_pulse();

      // abort and start together: abort wins
      play_abort = 1'b1; play_start = 1'b1; play_last = 4'd3;
      step();
      play_abort = 1'b0; play_start = 1'b0;
      chk("abort+start busy", play_busy, 1'b0);
      step(3);

      // async reset while a playback char sits in the holding register
      play(4'd2);
      v = 8'h00; n = 0;
      while (!v[7] && n < 50) begin cpu_rd(1'b1, v); n++; end
      chk("hold rdy", v[7], 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst dout", dout, 8'h00);
      chk("arst buf_rd", buf_rd, 1'b0);
      chk("arst busy", play_busy, 1'b0);
      chk("arst overrun", overrun, 1'b0);
      step();
      rst = 1'b0;
      step();
      cpu_rd(1'b1, v); chk("arst status", v, 8'h00);
      step(20);
      chk("arst idle busy", play_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
